// File: rtl/tmc_pio_pkg.sv
// tmc_pio_pkg
//   Shared constants for the TMC Nios II PIO slaves: Avalon word addresses
//   of the output PIO register map and the STATUS register bit positions.
package tmc_pio_pkg;

  localparam logic [2:0] PIO_ADDR_DATA      = 3'd0;
  localparam logic [2:0] PIO_ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] PIO_ADDR_OUT       = 3'd3;
  localparam logic [2:0] PIO_ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] PIO_ADDR_OUTCLEAR  = 3'd5;
  localparam logic [2:0] PIO_ADDR_PULSE     = 3'd6;
  localparam logic [2:0] PIO_ADDR_STATUS    = 3'd7;

  // STATUS layout: busy flag in bit 0, remaining pulse count from bit 16 up.
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_CNT_LSB  = 16;

endpackage

// File: rtl/tmc_pio_pulse_timer.sv
// tmc_pio_pulse_timer
//   Hardware-timed pulse engine for the output PIO. A start request with a
//   non-zero mask and non-zero length loads the mask and the down-counter;
//   the mask stays applied for exactly len cycles. A start while active
//   retriggers (reloads mask and count) and wins over that edge's countdown.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   start           : one-cycle PULSE register write strobe
//   mask, len       : pulse mask and length to load on a valid start
//   busy            : pulse in progress
//   mask_q, cnt_q   : applied mask and remaining cycle count (0 when idle)
module tmc_pio_pulse_timer
  import tmc_pio_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PULSE_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mask,
  input  logic [PULSE_W-1:0] len,
  output logic               busy,
  output logic [WIDTH-1:0]   mask_q,
  output logic [PULSE_W-1:0] cnt_q
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]         r_state;
  logic [WIDTH-1:0]   r_mask;
  logic [PULSE_W-1:0] r_cnt;
  logic               w_load;

  // Zero mask or zero length would be a no-op pulse; such writes are dropped.
  assign w_load = start && (|mask) && (|len);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_state <= ST_ACTIVE;
      r_mask  <= mask;
      r_cnt   <= len;
    end else if (r_state == ST_ACTIVE) begin
      if (r_cnt == PULSE_W'(1)) begin
        r_state <= ST_IDLE;
        r_mask  <= '0;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt - PULSE_W'(1);
      end
    end
  end

  assign busy   = (r_state == ST_ACTIVE);
  assign mask_q = r_mask;
  assign cnt_q  = r_cnt;

endmodule

// File: rtl/tmc_nios2_pio_out.sv
// tmc_nios2_pio_out
//   Avalon-MM output PIO slave. Drives out_port from a data register that
//   software updates directly or through atomic set/clear registers, plus a
//   hardware-timed pulse mask ORed on top while a pulse is running.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   address      : Avalon word address (3 bits)
//   chipselect   : slave select
//   write_n      : active-low write strobe
//   writedata    : 32-bit write data (low WIDTH / PULSE_W bits used)
//   readdata     : registered, zero-extended read data (latency 1)
//   out_port     : driven output lines
module tmc_nios2_pio_out
  import tmc_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PULSE_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]   r_data;
  logic [PULSE_W-1:0] r_len;
  logic [31:0]        r_readdata;

  logic               w_wr;
  logic [WIDTH-1:0]   w_wdata;
  logic               w_busy;
  logic [WIDTH-1:0]   w_mask;
  logic [PULSE_W-1:0] w_cnt;
  logic [WIDTH-1:0]   w_out;
  logic [31:0]        w_status;
  logic [31:0]        w_rd_mux;
  logic               w_unused_wdata;

  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[WIDTH-1:0];

  // Upper write-data bits are not stored anywhere.
  assign w_unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= RESET_VALUE;
      r_len  <= '0;
    end else if (w_wr) begin
      case (address)
        PIO_ADDR_DATA:      r_data <= w_wdata;
        PIO_ADDR_PULSE_LEN: r_len  <= writedata[PULSE_W-1:0];
        PIO_ADDR_OUTSET:    r_data <= r_data | w_wdata;
        PIO_ADDR_OUTCLEAR:  r_data <= r_data & ~w_wdata;
        default: ;
      endcase
    end
  end

  tmc_pio_pulse_timer #(
    .WIDTH   (WIDTH),
    .PULSE_W (PULSE_W)
  ) u_pulse_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (w_wr && (address == PIO_ADDR_PULSE)),
    .mask    (w_wdata),
    .len     (r_len),
    .busy    (w_busy),
    .mask_q  (w_mask),
    .cnt_q   (w_cnt)
  );

  // Register-only output path: no combinational route from the bus inputs.
  assign w_out    = r_data | (w_busy ? w_mask : '0);
  assign out_port = w_out;

  assign w_status = (32'(w_cnt) << STATUS_CNT_LSB) |
                    (32'(w_busy) << STATUS_BUSY_BIT);

  always_comb begin
    w_rd_mux = '0;
    case (address)
      PIO_ADDR_DATA:      w_rd_mux = 32'(r_data);
      PIO_ADDR_PULSE_LEN: w_rd_mux = 32'(r_len);
      PIO_ADDR_OUT:       w_rd_mux = 32'(w_out);
      PIO_ADDR_STATUS:    w_rd_mux = w_status;
      default:            w_rd_mux = '0;
    endcase
  end

  // Read mux is sampled every cycle, independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd_mux;
  end

  assign readdata = r_readdata;

endmodule
